// File: rtl/gate_truth_table_sequencer.sv
// Truth-table exerciser for a small combinational gate: sweeps every input
// vector, lets it settle, samples the gate output and scores it against an
// expected table. Reports observed table, mismatch count, first failing
// vector and an overall pass flag.
module gate_truth_table_sequencer #(
   parameter int unsigned              N_IN       = 2,
   parameter int unsigned              SETTLE_CYC = 2,
   parameter logic [(1<<N_IN)-1:0]     EXPECT     = 4'b1110
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          fail_count,
   output logic [N_IN-1:0]        first_fail_idx,
   output logic [(1<<N_IN)-1:0]   obs_table
);

   localparam int unsigned      CW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]    CNT_RELOAD = CW'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0]  LAST_VEC   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [N_IN-1:0]         vec_q, vec_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [N_IN-1:0]         din_q, din_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [N_IN:0]           fail_q, fail_d;
   logic [N_IN-1:0]         first_q, first_d;
   logic [(1<<N_IN)-1:0]    obs_q, obs_d;

   // State and result registers; reset aborts any sweep without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
         first_q <= '0;
         obs_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         first_q <= first_d;
         obs_q   <= obs_d;
      end
   end

   // Next-state and result update; everything holds unless the state acts on it.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      fail_d  = fail_q;
      first_d = first_q;
      obs_d   = obs_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               obs_d   = '0;
               fail_d  = '0;
               first_d = '0;
               pass_d  = 1'b0;
               vec_d   = '0;
               din_d   = '0;
               cnt_d   = CNT_RELOAD;
               busy_d  = 1'b1;
               state_d = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            obs_d[vec_q] = dut_out;
            if (dut_out != EXPECT[vec_q]) begin
               fail_d = fail_q + 1'b1;
               if (fail_q == '0) begin
                  first_d = vec_q;
               end
            end
            if (vec_q != LAST_VEC) begin
               vec_d   = vec_q + 1'b1;
               din_d   = vec_q + 1'b1;
               cnt_d   = CNT_RELOAD;
               state_d = S_SETTLE;
            end else begin
               // Verdict is registered alongside done so both are valid in the
               // same cycle, and it includes this final sample's outcome.
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (fail_d == '0);
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dut_in         = din_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail_count     = fail_q;
   assign first_fail_idx = first_q;
   assign obs_table      = obs_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench: four sequencer instances, each wired to a behavioural gate
// (OR, AND, OR with short settle, 3-input XOR), exercised one at a time.
module tb_gate_truth_table_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] st = '0;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned sel     = 0;

   // Instance 0: OR gate, defaults
   logic [1:0] or_din;   logic or_out;
   logic or_busy, or_done, or_pass;
   logic [2:0] or_fc;    logic [1:0] or_ff;   logic [3:0] or_obs;
   assign or_out = |or_din;

   // Instance 1: AND gate scored against the OR table
   logic [1:0] an_din;   logic an_out;
   logic an_busy, an_done, an_pass;
   logic [2:0] an_fc;    logic [1:0] an_ff;   logic [3:0] an_obs;
   assign an_out = &an_din;

   // Instance 2: OR gate, single settle cycle
   logic [1:0] s1_din;   logic s1_out;
   logic s1_busy, s1_done, s1_pass;
   logic [2:0] s1_fc;    logic [1:0] s1_ff;   logic [3:0] s1_obs;
   assign s1_out = |s1_din;

   // Instance 3: 3-input XOR
   logic [2:0] x3_din;   logic x3_out;
   logic x3_busy, x3_done, x3_pass;
   logic [3:0] x3_fc;    logic [2:0] x3_ff;   logic [7:0] x3_obs;
   assign x3_out = ^x3_din;

   gate_truth_table_sequencer #(.N_IN(2), .SETTLE_CYC(2), .EXPECT(4'b1110)) u_or (
      .clk(clk), .rst(rst), .start(st[0]), .dut_in(or_din), .dut_out(or_out),
      .busy(or_busy), .done(or_done), .pass(or_pass), .fail_count(or_fc),
      .first_fail_idx(or_ff), .obs_table(or_obs));

   gate_truth_table_sequencer #(.N_IN(2), .SETTLE_CYC(2), .EXPECT(4'b1110)) u_and (
      .clk(clk), .rst(rst), .start(st[1]), .dut_in(an_din), .dut_out(an_out),
      .busy(an_busy), .done(an_done), .pass(an_pass), .fail_count(an_fc),
      .first_fail_idx(an_ff), .obs_table(an_obs));

   gate_truth_table_sequencer #(.N_IN(2), .SETTLE_CYC(1), .EXPECT(4'b1110)) u_s1 (
      .clk(clk), .rst(rst), .start(st[2]), .dut_in(s1_din), .dut_out(s1_out),
      .busy(s1_busy), .done(s1_done), .pass(s1_pass), .fail_count(s1_fc),
      .first_fail_idx(s1_ff), .obs_table(s1_obs));

   gate_truth_table_sequencer #(.N_IN(3), .SETTLE_CYC(2), .EXPECT(8'b10010110)) u_x3 (
      .clk(clk), .rst(rst), .start(st[3]), .dut_in(x3_din), .dut_out(x3_out),
      .busy(x3_busy), .done(x3_done), .pass(x3_pass), .fail_count(x3_fc),
      .first_fail_idx(x3_ff), .obs_table(x3_obs));

   // Monitor mux: the instance under test, zero-extended
   logic [31:0] m_din, m_fc, m_ff, m_obs;
   logic        m_busy, m_done, m_pass;
   always_comb begin
      m_din = '0; m_fc = '0; m_ff = '0; m_obs = '0;
      m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
      case (sel)
         0: begin m_din = 32'(or_din); m_fc = 32'(or_fc); m_ff = 32'(or_ff); m_obs = 32'(or_obs);
                  m_busy = or_busy; m_done = or_done; m_pass = or_pass; end
         1: begin m_din = 32'(an_din); m_fc = 32'(an_fc); m_ff = 32'(an_ff); m_obs = 32'(an_obs);
                  m_busy = an_busy; m_done = an_done; m_pass = an_pass; end
         2: begin m_din = 32'(s1_din); m_fc = 32'(s1_fc); m_ff = 32'(s1_ff); m_obs = 32'(s1_obs);
                  m_busy = s1_busy; m_done = s1_done; m_pass = s1_pass; end
         default: begin m_din = 32'(x3_din); m_fc = 32'(x3_fc); m_ff = 32'(x3_ff); m_obs = 32'(x3_obs);
                  m_busy = x3_busy; m_done = x3_done; m_pass = x3_pass; end
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_results(input string tag, input logic [31:0] obs, input logic [31:0] fc,
                                input logic [31:0] ff, input logic pass_exp);
      check_eq({tag, " obs_table"},      m_obs, obs);
      check_eq({tag, " fail_count"},     m_fc,  fc);
      check_eq({tag, " first_fail_idx"}, m_ff,  ff);
      check_eq({tag, " pass"},           32'(m_pass), 32'(pass_exp));
   endtask

   // Full sweep on instance sel; j counts cycles after the start edge E.
   // noisy adds a start pulse mid-sweep and one sampled during the DONE cycle.
   task automatic sweep(input string tag, input int s, input int nv, input bit noisy);
      int done_at = -1;
      int ndone   = 0;
      int span    = nv * (s + 1);
      int exp_din;
      @(negedge clk);
      st[sel] = 1'b1;
      @(posedge clk); #1;
      st[sel] = 1'b0;
      for (int j = 0; j < span + 20; j++) begin
         exp_din = (j / (s + 1) < nv) ? j / (s + 1) : nv - 1;
         check_eq({tag, " dut_in"}, m_din, 32'(exp_din));
         check_eq({tag, " busy"},   32'(m_busy), 32'(j < span));
         if (m_done) begin
            ndone++;
            if (done_at < 0) done_at = j;
         end
         if (noisy) begin
            if (j == 4 || j == span)         st[sel] = 1'b1;
            if (j == 5 || j == span + 1)     st[sel] = 1'b0;
         end
         @(posedge clk); #1;
      end
      st[sel] = 1'b0;
      check_eq({tag, " done cycle"}, 32'(done_at), 32'(span));
      check_eq({tag, " done count"}, 32'(ndone), 32'd1);
   endtask

   initial begin
      // Reset state
      sel = 0;
      #2;
      check_eq("reset dut_in", m_din, 32'd0);
      check_eq("reset busy",   32'(m_busy), 32'd0);
      check_eq("reset done",   32'(m_done), 32'd0);
      check_results("reset", 32'h0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // OR gate, default table
      sweep("or", 2, 4, 1'b0);
      check_results("or", 32'hE, 32'd0, 32'd0, 1'b1);

      // Start pulses while busy and in DONE are ignored
      sweep("noisy", 2, 4, 1'b1);
      check_results("noisy", 32'hE, 32'd0, 32'd0, 1'b1);

      // Reset during vector 2 settle
      @(negedge clk);
      st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check_eq("pre-abort dut_in",    m_din, 32'd2);
      check_eq("pre-abort busy",      32'(m_busy), 32'd1);
      check_eq("pre-abort obs_table", m_obs, 32'h2);
      rst = 1'b1;
      #1;
      check_eq("abort dut_in", m_din, 32'd0);
      check_eq("abort busy",   32'(m_busy), 32'd0);
      check_eq("abort done",   32'(m_done), 32'd0);
      check_results("abort", 32'h0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      sweep("post-abort", 2, 4, 1'b0);
      check_results("post-abort", 32'hE, 32'd0, 32'd0, 1'b1);

      // AND gate against OR table: vectors 1 and 2 mismatch
      sel = 1;
      sweep("and", 2, 4, 1'b0);
      check_results("and", 32'h8, 32'd2, 32'd1, 1'b0);

      // Single settle cycle
      sel = 2;
      sweep("settle1", 1, 4, 1'b0);
      check_results("settle1", 32'hE, 32'd0, 32'd0, 1'b1);

      // Three-input XOR
      sel = 3;
      sweep("xor3", 2, 8, 1'b0);
      check_results("xor3", 32'h96, 32'd0, 32'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
